// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: sequencer state encodings, register-specifier
// width and the HALT opcode shared with control_unit.
package pipe_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [2:0] ST_RUN       = 3'd0;
  localparam logic [2:0] ST_STEP_WAIT = 3'd1;
  localparam logic [2:0] ST_STEP_EXEC = 3'd2;
  localparam logic [2:0] ST_DRAIN     = 3'd3;
  localparam logic [2:0] ST_HALTED    = 3'd4;

  localparam logic [5:0] OP_HALT = 6'h3F;

endpackage

// File: rtl/pipeline_sequencer_hazard_detect.sv
// Load-use hazard compare between the load in EX and the operands read in ID.
module hazard_detect
  import pipe_pkg::*;
#(
  parameter int ADDR_W = pipe_pkg::REG_ADDR_W
) (
  input  logic              id_ex_mem_read_i,
  input  logic [ADDR_W-1:0] id_ex_rt_i,
  input  logic [ADDR_W-1:0] if_id_rs_i,
  input  logic [ADDR_W-1:0] if_id_rt_i,
  input  logic              if_id_uses_rt_i,
  output logic              load_use_o
);

  // $zero never carries a real dependency, so a load targeting it never stalls.
  assign load_use_o = id_ex_mem_read_i && (id_ex_rt_i != '0) &&
                      ((id_ex_rt_i == if_id_rs_i) ||
                       (if_id_uses_rt_i && (id_ex_rt_i == if_id_rt_i)));

endmodule

// File: rtl/pipeline_sequencer.sv
// Run/stall/flush/step/halt controller for the 5-stage pipeline.
// Define PIPE_PERF_CNT_EN to add the cycle_cnt/stall_cnt performance counters.
module pipeline_sequencer #(
  parameter int REG_ADDR_W   = pipe_pkg::REG_ADDR_W,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  step_mode,
  input  logic                  step_req,
  input  logic                  halt_in_id,
  input  logic                  id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] id_ex_rt,
  input  logic [REG_ADDR_W-1:0] if_id_rs,
  input  logic [REG_ADDR_W-1:0] if_id_rt,
  input  logic                  if_id_uses_rt,
  input  logic                  branch_taken,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  pipe_en,
  output logic                  halted,
  output logic [2:0]            state_o
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic [CNT_W-1:0]      stall_cnt
`endif
);

  import pipe_pkg::*;

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  logic [2:0]    state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          step_req_q;
  logic          step_edge;
  logic          load_use;
  logic          active;

  hazard_detect #(.ADDR_W(REG_ADDR_W)) u_hazard (
    .id_ex_mem_read_i (id_ex_mem_read),
    .id_ex_rt_i       (id_ex_rt),
    .if_id_rs_i       (if_id_rs),
    .if_id_rt_i       (if_id_rt),
    .if_id_uses_rt_i  (if_id_uses_rt),
    .load_use_o       (load_use)
  );

  assign step_edge = step_req && !step_req_q;
  assign active    = (state_q == ST_RUN) || (state_q == ST_STEP_EXEC);
  assign state_o   = state_q;

  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_en      = 1'b0;
    halted       = 1'b0;
    case (state_q)
      ST_RUN, ST_STEP_EXEC: begin
        pipe_en = 1'b1;
        if (branch_taken) begin
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (load_use) begin
          id_ex_bubble = 1'b1;
        end else begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
        end
      end
      // Front end frozen while older instructions retire behind bubbles.
      ST_DRAIN: begin
        id_ex_bubble = 1'b1;
        pipe_en      = 1'b1;
      end
      ST_HALTED: halted = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      ST_RUN: begin
        if (halt_in_id && !branch_taken) begin
          state_d = ST_DRAIN;
          drain_d = DW'(DRAIN_CYCLES - 1);
        end else if (step_mode) begin
          state_d = ST_STEP_WAIT;
        end
      end
      ST_STEP_WAIT: begin
        if (!step_mode)     state_d = ST_RUN;
        else if (step_edge) state_d = ST_STEP_EXEC;
      end
      ST_STEP_EXEC: begin
        if (halt_in_id && !branch_taken) begin
          state_d = ST_DRAIN;
          drain_d = DW'(DRAIN_CYCLES - 1);
        end else begin
          state_d = step_mode ? ST_STEP_WAIT : ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) state_d = ST_HALTED;
        else               drain_d = drain_q - 1'b1;
      end
      default: state_d = ST_HALTED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      drain_q    <= '0;
      step_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      step_req_q <= step_req;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [CNT_W-1:0] cycle_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pipe_en) cycle_cnt_q <= sat_inc(cycle_cnt_q);
      if (active && !branch_taken && load_use) stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed self-checking bench for pipeline_sequencer (PIPE_PERF_CNT_EN optional).
module tb_pipeline_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       step_mode, step_req, halt_in_id, id_ex_mem_read, if_id_uses_rt, branch_taken;
  logic [4:0] id_ex_rt, if_id_rs, if_id_rt;
  logic       pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_en, halted;
  logic [2:0] state_o;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] cycle_cnt, stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  pipeline_sequencer dut (
    .clk(clk), .rst_n(rst_n), .step_mode(step_mode), .step_req(step_req),
    .halt_in_id(halt_in_id), .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .branch_taken(branch_taken), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .pipe_en(pipe_en),
    .halted(halted), .state_o(state_o)
`ifdef PIPE_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Packed view {state, pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_en, halted}
  function automatic logic [8:0] outs();
    return {state_o, pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_en, halted};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    step_mode = 0; step_req = 0; halt_in_id = 0; id_ex_mem_read = 0;
    id_ex_rt = 0; if_id_rs = 0; if_id_rt = 0; if_id_uses_rt = 0; branch_taken = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    #2;
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    #3;
    checks++;
    if (outs() !== {3'd0, 6'b110010}) begin
      errors++; $display("FAIL reset_outputs got=%b exp=%b", outs(), {3'd0, 6'b110010});
    end
`ifdef PIPE_PERF_CNT_EN
    checks++;
    if (cycle_cnt !== 0 || stall_cnt !== 0) begin
      errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", cycle_cnt, stall_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (outs() !== {3'd0, 6'b110010}) begin
        errors++; $display("FAIL free_run[%0d] got=%b exp=%b", i, outs(), {3'd0, 6'b110010});
      end
    end
  endtask

  task automatic test_load_use();
    id_ex_mem_read = 1; id_ex_rt = 8; if_id_rs = 8;
    #1;
    checks++;
    if (outs() !== {3'd0, 6'b000110}) begin
      errors++; $display("FAIL load_use_rs got=%b exp=%b", outs(), {3'd0, 6'b000110});
    end
    tick();
    id_ex_rt = 0; if_id_rs = 0;
    #1;
    checks++;
    if (outs() !== {3'd0, 6'b110010}) begin
      errors++; $display("FAIL load_use_zero got=%b exp=%b", outs(), {3'd0, 6'b110010});
    end
    id_ex_rt = 8; if_id_rs = 3; if_id_rt = 8; if_id_uses_rt = 1;
    #1;
    checks++;
    if (outs() !== {3'd0, 6'b000110}) begin
      errors++; $display("FAIL load_use_rt got=%b exp=%b", outs(), {3'd0, 6'b000110});
    end
    if_id_uses_rt = 0;
    #1;
    checks++;
    if (outs() !== {3'd0, 6'b110010}) begin
      errors++; $display("FAIL load_use_rt_unused got=%b exp=%b", outs(), {3'd0, 6'b110010});
    end
    id_ex_mem_read = 0; if_id_rs = 8; if_id_uses_rt = 1;
    #1;
    checks++;
    if (outs() !== {3'd0, 6'b110010}) begin
      errors++; $display("FAIL load_use_not_load got=%b exp=%b", outs(), {3'd0, 6'b110010});
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_branch_priority();
    id_ex_mem_read = 1; id_ex_rt = 9; if_id_rs = 9; branch_taken = 1;
    #1;
    checks++;
    if (outs() !== {3'd0, 6'b111110}) begin
      errors++; $display("FAIL branch_over_load_use got=%b exp=%b", outs(), {3'd0, 6'b111110});
    end
    halt_in_id = 1;
    tick();
    checks++;
    if (state_o !== 3'd0) begin
      errors++; $display("FAIL branch_flushes_halt state=%0d exp=0", state_o);
    end
    clear_inputs();
    #1;
  endtask

  task automatic test_single_step();
    int n;
    step_mode = 1;
    tick();
    checks++;
    if (outs() !== {3'd1, 6'b000000}) begin
      errors++; $display("FAIL step_wait got=%b exp=%b", outs(), {3'd1, 6'b000000});
    end
    // One-cycle pulse
    n = 0;
    step_req = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) step_req = 0;
      n += int'(pipe_en);
    end
    checks++;
    if (n !== 1) begin
      errors++; $display("FAIL step_pulse advances got=%0d exp=1", n);
    end
    // Level held for 5 cycles
    n = 0;
    step_req = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 4) step_req = 0;
      n += int'(pipe_en);
    end
    checks++;
    if (n !== 1) begin
      errors++; $display("FAIL step_held advances got=%0d exp=1", n);
    end
    checks++;
    if (state_o !== 3'd1) begin
      errors++; $display("FAIL step_back_to_wait state=%0d exp=1", state_o);
    end
    step_mode = 0;
    tick();
    checks++;
    if (outs() !== {3'd0, 6'b110010}) begin
      errors++; $display("FAIL step_exit got=%b exp=%b", outs(), {3'd0, 6'b110010});
    end
  endtask

  task automatic test_halt();
    halt_in_id = 1;
    tick();
    halt_in_id = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (outs() !== {3'd3, 6'b000110}) begin
        errors++; $display("FAIL drain[%0d] got=%b exp=%b", i, outs(), {3'd3, 6'b000110});
      end
      step_mode = 1; step_req = i[0];
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (outs() !== {3'd4, 6'b000001}) begin
        errors++; $display("FAIL halted[%0d] got=%b exp=%b", i, outs(), {3'd4, 6'b000001});
      end
      step_mode = 0;
      tick();
    end
    clear_inputs();
    do_reset();
    checks++;
    if (outs() !== {3'd0, 6'b110010}) begin
      errors++; $display("FAIL reset_from_halted got=%b exp=%b", outs(), {3'd0, 6'b110010});
    end
  endtask

  task automatic test_reset_mid_drain();
    halt_in_id = 1;
    tick();
    halt_in_id = 0;
    tick();
    checks++;
    if (state_o !== 3'd3) begin
      errors++; $display("FAIL drain_second state=%0d exp=3", state_o);
    end
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (outs() !== {3'd0, 6'b110010}) begin
      errors++; $display("FAIL async_reset_drain got=%b exp=%b", outs(), {3'd0, 6'b110010});
    end
    #2;
    rst_n = 1;
    tick();
    checks++;
    if (outs() !== {3'd0, 6'b110010}) begin
      errors++; $display("FAIL after_reset_drain got=%b exp=%b", outs(), {3'd0, 6'b110010});
    end
  endtask

`ifdef PIPE_PERF_CNT_EN
  task automatic test_perf_cnt();
    @(negedge clk);
    rst_n = 0;
    #1;
    clear_inputs();
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      id_ex_mem_read = (i == 3 || i == 6);
      id_ex_rt = 5'd4; if_id_rs = 5'd4;
      @(posedge clk);
    end
    #1;
    clear_inputs();
    checks++;
    if (cycle_cnt !== 32'd10) begin
      errors++; $display("FAIL perf_cycle_cnt got=%0d exp=10", cycle_cnt);
    end
    checks++;
    if (stall_cnt !== 32'd2) begin
      errors++; $display("FAIL perf_stall_cnt got=%0d exp=2", stall_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_free_run();
    test_load_use();
    test_branch_priority();
    test_single_step();
    test_halt();
    test_reset_mid_drain();
`ifdef PIPE_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
Central run/stall/flush controller for the 5-stage MIPS pipeline. It sits beside control_unit in the instruction-decode stage and drives the write-enables and flushes of PC, IF/ID and the downstream pipeline registers. It resolves load-use hazards, flushes on taken branches, supports debug single-step, and drains the pipeline then freezes it on a HALT instruction.

Parameters:
REG_ADDR_W, 5, register-specifier width
DRAIN_CYCLES, 3, cycles spent in DRAIN after HALT is seen in ID (covers EX, MEM, WB)
CNT_W, 32, width of the optional performance counters

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
step_mode  in  1  1 = debug single-step, 0 = free run
step_req  in  1  debug step request, level; rising edge = one step
halt_in_id  in  1  HALT opcode decoded in ID
id_ex_mem_read  in  1  instruction in EX is a load
id_ex_rt  in  REG_ADDR_W  load destination in EX
if_id_rs  in  REG_ADDR_W  rs of instruction in ID
if_id_rt  in  REG_ADDR_W  rt of instruction in ID
if_id_uses_rt  in  1  ID instruction reads rt
branch_taken  in  1  branch/jump resolved taken this cycle
pc_write  out  1  PC load enable
if_id_write  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID load with NOP
id_ex_bubble  out  1  zero ex/mem/wb control fields into ID/EX
pipe_en  out  1  enable for ID/EX, EX/MEM, MEM/WB
halted  out  1  pipeline frozen after HALT
state_o  out  3  current FSM state, for debug

Behaviour:
- Reset (async, rst_n=0): state=RUN, drain counter=0, step-edge register=0, counters=0. Combinational outputs take RUN values with no hazard: pc_write=1, if_id_write=1, pipe_en=1, other outputs 0.
- Encoding: RUN=0, STEP_WAIT=1, STEP_EXEC=2, DRAIN=3, HALTED=4.
- load_use = id_ex_mem_read & (id_ex_rt!=0) & (id_ex_rt==if_id_rs | (if_id_uses_rt & id_ex_rt==if_id_rt)).
- Active states (RUN, STEP_EXEC), outputs are combinational, zero latency:
  - branch_taken: if_id_flush=1, id_ex_bubble=1, pc_write=1. Branch has priority over load_use.
  - else load_use: pc_write=0, if_id_write=0, id_ex_bubble=1, pipe_en=1.
  - else all enables 1.
- STEP_WAIT: pc_write=if_id_write=pipe_en=0, no flush or bubble. The whole pipeline holds.
- step_edge = step_req & ~step_req_q, where step_req_q is registered each cycle.
- Transitions (priority top-down):
  - HALTED: stays until reset.
  - halt_in_id in RUN or STEP_EXEC, with no branch_taken: go to DRAIN, counter=DRAIN_CYCLES-1. A taken branch wins because the HALT is flushed.
  - RUN with step_mode=1: go to STEP_WAIT.
  - STEP_WAIT with step_mode=0: go to RUN. With step_edge: go to STEP_EXEC.
  - STEP_EXEC: go to STEP_WAIT, or RUN if step_mode=0. Exactly one clock of advance per step_edge. A stalled step still counts as one step.
  - DRAIN: pc_write=0, if_id_write=0, id_ex_bubble=1, pipe_en=1. The counter decrements each cycle; at 0 go to HALTED. step_mode and step_req are ignored.
  - HALTED: all enables 0, halted=1.
- A step_req held high yields one step only. A new step needs a low-then-high transition.
- An async reset in any state, including mid-DRAIN, returns to RUN within the same cycle.

Optional Feature:
PIPE_PERF_CNT_EN:
- Defined: adds outputs cycle_cnt and stall_cnt, each CNT_W bits.
  - cycle_cnt increments every cycle with pipe_en=1.
  - stall_cnt increments every cycle with load_use bubble inserted.
  - Both saturate at all-ones and reset to 0.
- Undefined: the ports and logic are absent.

Decomposition:
- Shared package pipe_pkg holds:
  - state encodings ST_RUN..ST_HALTED
  - REG_ADDR_W
  - the HALT opcode constant, also used by control_unit
- One natural sub-module, hazard_detect: the combinational load_use compare. It is reused later for forwarding checks.

Test Plan:
1. Reset then free run, no hazards: pc_write=if_id_write=pipe_en=1, state_o=0 on every cycle.
2. Load-use hazard: id_ex_mem_read=1, id_ex_rt=8, if_id_rs=8 for one cycle gives pc_write=0, if_id_write=0, id_ex_bubble=1 that cycle. With id_ex_rt=0, no stall occurs.
3. Branch and load-use together: branch_taken=1 plus a load-use match gives if_id_flush=1, id_ex_bubble=1, pc_write=1.
4. Single-step: step_mode=1 gives state 1 with all enables 0. One step_req pulse gives exactly one cycle with pipe_en=1. Holding step_req high for 5 cycles still gives exactly one. Setting step_mode=0 returns to RUN.
5. HALT: halt_in_id=1 gives DRAIN for 3 cycles with id_ex_bubble=1, then halted=1 and enables 0 indefinitely. Asserting rst_n=0 in the second DRAIN cycle gives RUN immediately.
6. With PIPE_PERF_CNT_EN defined: 10 run cycles containing 2 load-use stalls give cycle_cnt=10, stall_cnt=2.
